// File: rtl/bod_pkg.sv
// Shared types and helpers for the brownout trim sequencer: trim code widths,
// sequencer states and the 3->8 one-hot decode used by both trim paths.
package bod_pkg;

  localparam int TRIP_W = 3;
  localparam int NSEL   = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    BLANK  = 2'd3
  } bod_state_t;

  function automatic logic [NSEL-1:0] onehot8(input logic [TRIP_W-1:0] code);
    logic [NSEL-1:0] sel;
    sel       = '0;
    sel[code] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/bod_trim_decode.sv
// Registered 3->8 one-hot trim select. Reset parks the select on tap 0 so the
// ladder mux never sees an all-zero select.
module bod_trim_decode
  import bod_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [TRIP_W-1:0] code_i,
  output logic [NSEL-1:0]   sel_o
);

  logic [NSEL-1:0] sel_q;

  // The whole word is replaced in one edge, so the select goes straight from one
  // one-hot value to the next with no intermediate pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= NSEL'(1);
    end else if (load_i) begin
      sel_q <= onehot8(code_i);
    end
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/bod_trim_seq.sv
// Brownout ladder control: sequences enable settling, applies trim codes and
// blanks the comparators while the resistor string settles after a trim change.
module bod_trim_seq
  import bod_pkg::*;
#(
  parameter int SETTLE_CYC = 64,
  parameter int BLANK_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  input  logic [TRIP_W-1:0] otrip,
  input  logic [TRIP_W-1:0] vtrip,
  output logic              ena,
  output logic [NSEL-1:0]   otrip_decoded,
  output logic [NSEL-1:0]   vtrip_decoded,
  output logic              ready,
  output logic              blank
);

  localparam int MAX_CYC = (SETTLE_CYC > BLANK_CYC) ? SETTLE_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYC - 1);

  bod_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ena_q, ready_q, blank_q;
  logic             loadCodes;
  logic             codeChange;

  // The applied codes live in the decoders; comparing against them catches a
  // change on either trim (or both) as a single event.
  assign codeChange = (otrip_decoded != onehot8(otrip)) ||
                      (vtrip_decoded != onehot8(vtrip));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loadCodes = 1'b0;
    unique case (state_q)
      OFF: begin
        loadCodes = 1'b1;
        if (ena_in) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (codeChange) begin
          loadCodes = 1'b1;
          cnt_d     = SETTLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (codeChange) begin
          loadCodes = 1'b1;
          state_d   = BLANK;
          cnt_d     = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (codeChange) begin
          loadCodes = 1'b1;
          cnt_d     = BLANK_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
    // Dropping the enable request overrides any settle/blank activity.
    if (!ena_in) begin
      state_d   = OFF;
      cnt_d     = '0;
      loadCodes = 1'b1;
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      ready_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ena_q   <= (state_d != OFF);
      ready_q <= (state_d == ACTIVE);
      blank_q <= (state_d != ACTIVE);
    end
  end

  bod_trim_decode u_otrip_dec (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadCodes),
    .code_i (otrip),
    .sel_o  (otrip_decoded)
  );

  bod_trim_decode u_vtrip_dec (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadCodes),
    .code_i (vtrip),
    .sel_o  (vtrip_decoded)
  );

  assign ena   = ena_q;
  assign ready = ready_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bod_trim_seq.sv
// Self-checking bench for bod_trim_seq: vector table, directed settle/blank
// sequences and randomized traffic against a cycles-remaining reference model.
module tb_bod_trim_seq;

  localparam int SETTLE = 64;
  localparam int BLANK  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enaIn = 1'b0;
  logic [2:0] otrip = 3'd0;
  logic [2:0] vtrip = 3'd0;
  logic       ena, ready, blank;
  logic [7:0] oDec, vDec;

  int errors = 0;
  int checks = 0;

  bod_trim_seq #(.SETTLE_CYC(SETTLE), .BLANK_CYC(BLANK)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena_in        (enaIn),
    .otrip         (otrip),
    .vtrip         (vtrip),
    .ena           (ena),
    .otrip_decoded (oDec),
    .vtrip_decoded (vDec),
    .ready         (ready),
    .blank         (blank)
  );

  always #5 clk = ~clk;

  // Reference model: enabled flag, applied codes, and edges left until ready.
  bit         mEna;
  bit         mSettled;
  int         mRemaining;
  logic [2:0] mO, mV;

  task automatic modelStep();
    if (rst) begin
      mEna = 0; mSettled = 0; mRemaining = 0; mO = 3'd0; mV = 3'd0;
    end else if (!enaIn) begin
      mEna = 0; mSettled = 0; mRemaining = 0; mO = otrip; mV = vtrip;
    end else if (!mEna) begin
      mEna = 1; mO = otrip; mV = vtrip; mRemaining = SETTLE;
    end else if (otrip != mO || vtrip != mV) begin
      mO = otrip; mV = vtrip;
      mRemaining = mSettled ? BLANK : SETTLE;
    end else if (mRemaining > 0) begin
      mRemaining--;
      if (mRemaining == 0) mSettled = 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] o, input logic [2:0] v);
    rst = r; enaIn = e; otrip = o; vtrip = v;
  endtask

  // One clock: advance the model with the inputs the DUT samples, then check invariants.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("onehot_otrip", {7'd0, $onehot(oDec)}, 8'd1);
    checkOutput("onehot_vtrip", {7'd0, $onehot(vDec)}, 8'd1);
    checkOutput("ready_blank_excl", {7'd0, ready & blank}, 8'd0);
  endtask

  task automatic checkAll(input string tag, input logic eEna, input logic eRdy, input logic eBlk,
                          input logic [7:0] eO, input logic [7:0] eV);
    checkOutput({tag, "_ena"},   {7'd0, ena},   {7'd0, eEna});
    checkOutput({tag, "_ready"}, {7'd0, ready}, {7'd0, eRdy});
    checkOutput({tag, "_blank"}, {7'd0, blank}, {7'd0, eBlk});
    checkOutput({tag, "_otrip"}, oDec, eO);
    checkOutput({tag, "_vtrip"}, vDec, eV);
  endtask

  typedef struct {
    logic       r, e;
    logic [2:0] o, v;
    logic       eEna, eRdy, eBlk;
    logic [7:0] eO, eV;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01};
    tbl[1] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01};
    tbl[3] = '{1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01};
    tbl[4] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b1, 8'h20, 8'h04};
    tbl[5] = '{1'b0, 1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 8'h08, 8'h40};
    tbl[6] = '{1'b0, 1'b1, 3'd3, 3'd6, 1'b1, 1'b0, 1'b1, 8'h08, 8'h40};
    tbl[7] = '{1'b0, 1'b0, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1, 8'h02, 8'h40};
    tbl[8] = '{1'b0, 1'b0, 3'd1, 3'd7, 1'b0, 1'b0, 1'b1, 8'h02, 8'h80};
    tbl[9] = '{1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].r, tbl[i].e, tbl[i].o, tbl[i].v);
      tick();
      checkAll($sformatf("vec%0d", i), tbl[i].eEna, tbl[i].eRdy, tbl[i].eBlk, tbl[i].eO, tbl[i].eV);
    end

    // Enable settling: ready exactly SETTLE edges after ena rises.
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 3'd3, 3'd6);
    tick();
    checkAll("settle_start", 1'b1, 1'b0, 1'b1, 8'h08, 8'h40);
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      checkOutput("settle_not_ready", {7'd0, ready}, 8'd0);
    end
    tick();
    checkAll("settle_done", 1'b1, 1'b1, 1'b0, 8'h08, 8'h40);

    // Trim change while active: atomic switch, BLANK edges of blanking.
    applyStimulus(1'b0, 1'b1, 3'd3, 3'd2);
    tick();
    checkAll("blank_start", 1'b1, 1'b0, 1'b1, 8'h08, 8'h04);
    for (int i = 1; i < BLANK; i++) begin
      tick();
      checkOutput("blank_hold", {7'd0, blank}, 8'd1);
    end
    tick();
    checkAll("blank_done", 1'b1, 1'b1, 1'b0, 8'h08, 8'h04);

    // Further change mid-blank restarts the full blank window.
    applyStimulus(1'b0, 1'b1, 3'd3, 3'd6);
    tick();
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(1'b0, 1'b1, 3'd7, 3'd6);
    tick();
    checkAll("reblank_start", 1'b1, 1'b0, 1'b1, 8'h80, 8'h40);
    for (int i = 1; i < BLANK; i++) begin
      tick();
      checkOutput("reblank_hold", {7'd0, blank}, 8'd1);
    end
    tick();
    checkAll("reblank_done", 1'b1, 1'b1, 1'b0, 8'h80, 8'h40);

    // Reset while active returns everything to reset values.
    applyStimulus(1'b1, 1'b1, 3'd7, 3'd6);
    tick();
    checkAll("reset_active", 1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    applyStimulus(1'b0, 1'b0, 3'd7, 3'd6);
    tick();
    checkAll("off_track", 1'b0, 1'b0, 1'b1, 8'h80, 8'h40);

    // Disable with a simultaneous code change during settle.
    applyStimulus(1'b0, 1'b1, 3'd7, 3'd6);
    tick();
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(1'b0, 1'b0, 3'd2, 3'd6);
    tick();
    checkAll("disable_settle", 1'b0, 1'b0, 1'b1, 8'h04, 8'h40);
    applyStimulus(1'b0, 1'b0, 3'd6, 3'd6);
    tick();
    checkAll("off_decode", 1'b0, 1'b0, 1'b1, 8'h40, 8'h40);

    // Code change during settle restarts the settle count.
    applyStimulus(1'b0, 1'b1, 3'd6, 3'd6);
    tick();
    for (int i = 0; i < 10; i++) tick();
    applyStimulus(1'b0, 1'b1, 3'd1, 3'd6);
    tick();
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      checkOutput("resettle_not_ready", {7'd0, ready}, 8'd0);
    end
    tick();
    checkAll("resettle_done", 1'b1, 1'b1, 1'b0, 8'h02, 8'h40);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 5000; i++) begin
      logic       r, e;
      logic [2:0] o, v;
      r = ($urandom_range(0, 1999) == 0);
      e = enaIn ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 9) == 0);
      o = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(0, 7)) : otrip;
      v = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(0, 7)) : vtrip;
      applyStimulus(r, e, o, v);
      tick();
      checkAll("rand", mEna, mEna && (mRemaining == 0), !(mEna && (mRemaining == 0)),
               8'(1) << mO, 8'(1) << mV);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
